// File: rtl/pll_reset_sequencer_if.sv
// Interface bundling the lock/soft-reset inputs and the staged reset outputs
// of pll_reset_sequencer. The master side is the controlling logic (PLL lock
// and soft-reset source, reset consumers); the slave side is the sequencer.
// The optional lock_loss_cnt signal exists only when LOCK_LOSS_CNT_EN is defined.
interface pll_reset_sequencer_if;
    logic       locked_in;
    logic       soft_rst_req;
    logic       soft_rst_ack;
    logic       rst_core_n;
    logic       rst_usb_n;
    logic       ready;
    logic [2:0] state_dbg;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

`ifdef LOCK_LOSS_CNT_EN
    modport master (
        output locked_in,
        output soft_rst_req,
        input  soft_rst_ack,
        input  rst_core_n,
        input  rst_usb_n,
        input  ready,
        input  state_dbg,
        input  lock_loss_cnt
    );

    modport slave (
        input  locked_in,
        input  soft_rst_req,
        output soft_rst_ack,
        output rst_core_n,
        output rst_usb_n,
        output ready,
        output state_dbg,
        output lock_loss_cnt
    );
`else
    modport master (
        output locked_in,
        output soft_rst_req,
        input  soft_rst_ack,
        input  rst_core_n,
        input  rst_usb_n,
        input  ready,
        input  state_dbg
    );

    modport slave (
        input  locked_in,
        input  soft_rst_req,
        output soft_rst_ack,
        output rst_core_n,
        output rst_usb_n,
        output ready,
        output state_dbg
    );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies PLL lock stability, then releases staged
// active-low resets (core first, USB HID host STAGE_DELAY cycles later).
// Lock loss drops every reset at once and restarts qualification; a soft
// reset request in RUN replays only the hold/release part of the sequence.
// Optional feature macro: LOCK_LOSS_CNT_EN adds a saturating 8-bit count of
// lock losses that happen after qualification (HOLD, CORE_UP or RUN).
module pll_reset_sequencer #(
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 256,
    parameter int STAGE_DELAY   = 64
) (
    input  logic                  clock_in,
    input  logic                  rst_n_in,
    pll_reset_sequencer_if.slave  bus
);

    localparam int MAX_SH  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_ALL = (MAX_SH > STAGE_DELAY) ? MAX_SH : STAGE_DELAY;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    // Terminal counts for each timed state.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        HOLD      = 3'd2,
        CORE_UP   = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             ack_reg;
    logic             ack_next;
    logic             rst_core_n_reg;
    logic             rst_core_n_next;
    logic             rst_usb_n_reg;
    logic             rst_usb_n_next;
    logic             ready_reg;
    logic             ready_next;

    // Next-state logic; reset outputs are decoded from the next state so the
    // registered outputs change on the same edge as the state itself.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ack_next   = 1'b0;

        case (state_reg)
            WAIT_LOCK: begin
                cnt_next = '0;
                if (bus.locked_in) begin
                    state_next = STABLE;
                end
            end

            STABLE: begin
                if (!bus.locked_in) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            HOLD: begin
                if (!bus.locked_in) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = CORE_UP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            CORE_UP: begin
                if (!bus.locked_in) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == STAGE_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            RUN: begin
                // Lock loss takes priority over a simultaneous soft request.
                if (!bus.locked_in) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (bus.soft_rst_req) begin
                    // Lock is already qualified, so the replay starts at HOLD.
                    state_next = HOLD;
                    cnt_next   = '0;
                    ack_next   = 1'b1;
                end
            end

            default: begin
                // Unused encodings recover to a safe, fully-reset state.
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase

        rst_core_n_next = (state_next == CORE_UP) || (state_next == RUN);
        rst_usb_n_next  = (state_next == RUN);
        ready_next      = (state_next == RUN);
    end

    // State, counter and registered outputs; async reset holds every reset asserted.
    always_ff @(posedge clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg      <= WAIT_LOCK;
            cnt_reg        <= '0;
            ack_reg        <= 1'b0;
            rst_core_n_reg <= 1'b0;
            rst_usb_n_reg  <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            ack_reg        <= ack_next;
            rst_core_n_reg <= rst_core_n_next;
            rst_usb_n_reg  <= rst_usb_n_next;
            ready_reg      <= ready_next;
        end
    end

    assign bus.soft_rst_ack = ack_reg;
    assign bus.rst_core_n   = rst_core_n_reg;
    assign bus.rst_usb_n    = rst_usb_n_reg;
    assign bus.ready        = ready_reg;
    assign bus.state_dbg    = state_reg;

`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt_reg;
    logic [7:0] lock_loss_cnt_next;
    logic       lock_lost;

    // Count only losses after qualification; losses during STABLE are expected jitter.
    always_comb begin
        lock_lost          = !bus.locked_in &&
                             ((state_reg == HOLD) || (state_reg == CORE_UP) || (state_reg == RUN));
        lock_loss_cnt_next = lock_loss_cnt_reg;
        if (lock_lost && (lock_loss_cnt_reg != 8'hFF)) begin
            lock_loss_cnt_next = lock_loss_cnt_reg + 8'd1;
        end
    end

    // Saturating lock-loss counter register.
    always_ff @(posedge clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lock_loss_cnt_reg <= 8'd0;
        end else begin
            lock_loss_cnt_reg <= lock_loss_cnt_next;
        end
    end

    assign bus.lock_loss_cnt = lock_loss_cnt_reg;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer. A reference model computes expected
// outputs from the elapsed locked time since the sequence start and pushes
// them into a queue at each clock edge; a monitor pops and compares on the
// falling edge, and also checks asynchronous reset assertion mid-cycle.
module tb_pll_reset_sequencer;

    localparam int S = 8;
    localparam int H = 4;
    localparam int D = 2;

    logic clock_in;
    logic rst_n_in;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .STABLE_CYCLES (S),
        .HOLD_CYCLES   (H),
        .STAGE_DELAY   (D)
    ) dut (
        .clock_in (clock_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    typedef struct packed {
        logic       ack;
        logic       core;
        logic       usb;
        logic       rdy;
        logic [2:0] st;
        logic [7:0] llc;
    } exp_t;

    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    initial clock_in = 1'b0;
    always #10 clock_in = ~clock_in;

    // Reference model: phase = locked edges since sequence start (-1: waiting for lock).
    int         phase = -1;
    logic       m_ack = 1'b0;
    logic [7:0] m_llc = 8'd0;

    always @(posedge clock_in) begin
        exp_t e;
        cycle++;
        m_ack = 1'b0;
        if (!rst_n_in) begin
            phase = -1;
            m_llc = 8'd0;
        end else if (!bus.locked_in) begin
            if (phase >= S && m_llc != 8'd255) m_llc = m_llc + 8'd1;
            phase = -1;
        end else if (phase < 0) begin
            phase = 0;
        end else if (phase >= S + H + D && bus.soft_rst_req) begin
            phase = S;
            m_ack = 1'b1;
        end else if (phase < S + H + D) begin
            phase++;
        end
        e.ack  = m_ack;
        e.core = (phase >= S + H);
        e.usb  = (phase >= S + H + D);
        e.rdy  = (phase >= S + H + D);
        e.st   = (phase < 0) ? 3'd0 : (phase < S) ? 3'd1 : (phase < S + H) ? 3'd2 :
                 (phase < S + H + D) ? 3'd3 : 3'd4;
`ifdef LOCK_LOSS_CNT_EN
        e.llc  = m_llc;
`else
        e.llc  = 8'd0;
`endif
        exp_q.push_back(e);
    end

    // Monitor: compare each edge's outputs, then check async reset before the next edge.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clock_in);
            got.ack  = bus.soft_rst_ack;
            got.core = bus.rst_core_n;
            got.usb  = bus.rst_usb_n;
            got.rdy  = bus.ready;
            got.st   = bus.state_dbg;
`ifdef LOCK_LOSS_CNT_EN
            got.llc  = bus.lock_loss_cnt;
`else
            got.llc  = 8'd0;
`endif
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compared++;
                if (got !== e) begin
                    mismatched++;
                    $display("FAIL outputs cycle %0d: got ack=%b core=%b usb=%b rdy=%b st=%0d llc=%0d, required ack=%b core=%b usb=%b rdy=%b st=%0d llc=%0d",
                             cycle, got.ack, got.core, got.usb, got.rdy, got.st, got.llc,
                             e.ack, e.core, e.usb, e.rdy, e.st, e.llc);
                end else begin
                    $display("cycle %0d ok: ack=%b core=%b usb=%b rdy=%b st=%0d llc=%0d",
                             cycle, got.ack, got.core, got.usb, got.rdy, got.st, got.llc);
                end
                compared++;
                if (got.usb && !got.core) begin
                    mismatched++;
                    $display("FAIL ordering cycle %0d: got usb=%b core=%b, required core=1 whenever usb=1",
                             cycle, got.usb, got.core);
                end
            end
            #2;
            if (!rst_n_in) begin
                compared++;
                if ({bus.soft_rst_ack, bus.rst_core_n, bus.rst_usb_n, bus.ready, bus.state_dbg} !== 7'd0) begin
                    mismatched++;
                    $display("FAIL async_reset cycle %0d: got ack=%b core=%b usb=%b rdy=%b st=%0d, required all 0",
                             cycle, bus.soft_rst_ack, bus.rst_core_n, bus.rst_usb_n, bus.ready, bus.state_dbg);
                end
            end
        end
    end

    task automatic drive(input logic lk, input logic rq, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock_in);
            #1;
            bus.locked_in    = lk;
            bus.soft_rst_req = rq;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock_in);
        #1;
        rst_n_in = 1'b0;
        @(negedge clock_in);
        #1;
        rst_n_in = 1'b1;
    endtask

    initial begin
        rst_n_in         = 1'b0;
        bus.locked_in    = 1'b0;
        bus.soft_rst_req = 1'b0;

        // Reset state, then power-up with a clean lock.
        drive(1'b0, 1'b0, 3);
        @(negedge clock_in);
        #1;
        rst_n_in = 1'b1;
        drive(1'b1, 1'b0, 20);

        // Lock drop in RUN.
        drive(1'b0, 1'b0, 2);

        // Glitchy lock: high 5, low 1, then high until RUN.
        drive(1'b1, 1'b0, 5);
        drive(1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 18);

        // Single-cycle soft reset in RUN, then let it complete.
        drive(1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, 10);

        // Soft request and lock loss on the same edge.
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 2);

        // Held soft request re-fires every time RUN is reached.
        drive(1'b1, 1'b1, 40);
        drive(1'b1, 1'b0, 10);

        // Asynchronous reset while in CORE_UP.
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 13);
        pulse_reset();
        drive(1'b1, 1'b0, 16);

        // Randomized lock, soft request and occasional reset.
        for (int i = 0; i < 500; i++) begin
            @(negedge clock_in);
            #1;
            bus.locked_in    = ($urandom_range(0, 15) != 0);
            bus.soft_rst_req = ($urandom_range(0, 7) == 0);
            rst_n_in         = ($urandom_range(0, 49) != 0);
        end
        @(negedge clock_in);
        #1;
        rst_n_in = 1'b1;

        // 300 post-qualification lock losses to saturate the counter.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, S + 1);
            drive(1'b0, 1'b0, 1);
        end
        drive(1'b1, 1'b0, S + 1);
        drive(1'b0, 1'b0, 3);

        @(negedge clock_in);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
